// File: rtl/neopixel_stream_engine_pkg.sv
// Shared state encoding, default sizing and waveform timing for the WS2812 stream engine.
// No logic of its own; imported by the counters and the engine top.
package neopixel_stream_engine_pkg;

  typedef enum logic {
    ENUM_STATE_TRANSMIT = 1'b0,
    ENUM_STATE_RESET    = 1'b1
  } state_e;

  localparam int BUFFER_END_DEFAULT  = 31;
  localparam int RESET_DELAY_DEFAULT = 385;

  // Number of 8-tick pattern slots the line is held high for each bit value.
  localparam logic [2:0] HIGH_TICKS_ONE  = 3'd5;
  localparam logic [2:0] HIGH_TICKS_ZERO = 3'd2;

  localparam logic [2:0] LAST_PATTERN = 3'd7;
  localparam logic [4:0] LAST_BIT_8   = 5'd7;
  localparam logic [4:0] LAST_BIT_32  = 5'd23;

  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/neopixel_stream_engine_counters.sv
// Tick, bit and pixel counters with overflow flags and the byte address into the pixel buffer.
// Counters update on every enabled tick; they have no stall input and clear while disabled.
module neopixel_stream_counters
  import neopixel_stream_engine_pkg::*;
#(
  parameter int BUFFER_END = BUFFER_END_DEFAULT,
  localparam int BUFFER_BITS = clog2(BUFFER_END + 1)
) (
  input  logic                   clk7mhz,
  input  logic                   reset,
  input  logic                   init,
  input  logic                   advance,
  input  logic                   mode_32bit,
  input  logic                   limit,
  input  logic [12:0]            reg_max,
  output logic [2:0]             bit_pattern_index,
  output logic [2:0]             bit_in_byte,
  output logic [BUFFER_BITS-1:0] mem_addr,
  output logic                   pixel_of
);

  localparam logic [BUFFER_BITS-1:0] END_ADDR    = BUFFER_BITS'(BUFFER_END);
  localparam logic [BUFFER_BITS-1:0] STRIDE_MASK = ~BUFFER_BITS'(3);
  localparam logic [BUFFER_BITS-1:0] STEP_8      = BUFFER_BITS'(1);
  localparam logic [BUFFER_BITS-1:0] STEP_32     = BUFFER_BITS'(4);

  logic [2:0]             bit_pattern_index_q, bit_pattern_index_d;
  logic [4:0]             pixel_bit_index_q, pixel_bit_index_d;
  logic [BUFFER_BITS-1:0] pixel_index_q, pixel_index_d;

  logic [BUFFER_BITS-1:0] pixel_index_max;
  logic [BUFFER_BITS-1:0] pixel_step;
  logic [4:0]             last_bit;
  logic                   pattern_of;
  logic                   bit_of;

  always_comb begin
    pixel_index_max = END_ADDR;
    if (limit) begin
      pixel_index_max = mode_32bit ? BUFFER_BITS'({reg_max, 2'b00}) : BUFFER_BITS'(reg_max);
    end else if (mode_32bit) begin
      pixel_index_max = END_ADDR & STRIDE_MASK;
    end
  end

  always_comb begin
    last_bit   = mode_32bit ? LAST_BIT_32 : LAST_BIT_8;
    pixel_step = mode_32bit ? STEP_32 : STEP_8;
    pattern_of = advance && (bit_pattern_index_q == LAST_PATTERN);
    bit_of     = pattern_of && (pixel_bit_index_q == last_bit);
    // >= rather than == so a max changed mid-frame still ends the frame.
    pixel_of   = bit_of && (pixel_index_q >= pixel_index_max);
  end

  always_comb begin
    bit_pattern_index_d = bit_pattern_index_q;
    pixel_bit_index_d   = pixel_bit_index_q;
    pixel_index_d       = pixel_index_q;
    if (init || !advance) begin
      bit_pattern_index_d = '0;
      pixel_bit_index_d   = '0;
      pixel_index_d       = '0;
    end else begin
      bit_pattern_index_d = bit_pattern_index_q + 3'd1;
      if (pattern_of) begin
        pixel_bit_index_d = bit_of ? 5'd0 : pixel_bit_index_q + 5'd1;
      end
      if (bit_of) begin
        pixel_index_d = pixel_of ? '0 : pixel_index_q + pixel_step;
      end
    end
  end

  always_ff @(posedge clk7mhz) begin
    if (reset) begin
      bit_pattern_index_q <= '0;
      pixel_bit_index_q   <= '0;
      pixel_index_q       <= '0;
    end else begin
      bit_pattern_index_q <= bit_pattern_index_d;
      pixel_bit_index_q   <= pixel_bit_index_d;
      pixel_index_q       <= pixel_index_d;
    end
  end

  always_comb begin
    bit_pattern_index = bit_pattern_index_q;
    bit_in_byte       = pixel_bit_index_q[2:0];
    mem_addr          = pixel_index_q;
    if (mode_32bit) begin
      mem_addr = pixel_index_q + BUFFER_BITS'(pixel_bit_index_q[4:3]);
    end
  end

endmodule

// File: rtl/neopixel_stream_engine.sv
// WS2812 serialiser: streams buffer bytes MSB-first as 8-tick bit cells, then holds a latch reset.
// neoData lags the counters by one tick; a dropped run aborts the frame, a started reset always completes.
module neopixel_stream_engine
  import neopixel_stream_engine_pkg::*;
#(
  parameter int BUFFER_END  = BUFFER_END_DEFAULT,
  parameter int RESET_DELAY = RESET_DELAY_DEFAULT,
  localparam int BUFFER_BITS = clog2(BUFFER_END + 1)
) (
  input  logic                   clk7mhz,
  input  logic                   reset,
  input  logic                   reg_ctrl_init,
  input  logic                   reg_ctrl_run,
  input  logic                   reg_ctrl_loop,
  input  logic                   reg_ctrl_limit,
  input  logic                   reg_ctrl_32bit,
  input  logic [12:0]            reg_max,
  output logic [BUFFER_BITS-1:0] memAddr,
  input  logic [7:0]             memData,
  output logic                   neoData,
  output logic                   neoState,
  output logic                   pixelsSync,
  output logic                   stateReset,
  output logic                   runClear
);

  localparam logic [9:0] DELAY_LAST = 10'(RESET_DELAY);

  state_e     state_q, state_d;
  logic [9:0] delay_count_q, delay_count_d;
  logic       neo_data_q, neo_data_d;
  logic       pixels_sync_q, pixels_sync_d;
  logic       state_reset_q, state_reset_d;
  logic       run_clear_q, run_clear_d;

  logic       stream_output;
  logic [2:0] bit_pattern_index;
  logic [2:0] bit_in_byte;
  logic       pixel_of;
  logic       data_bit;
  logic [2:0] high_ticks;

  assign stream_output = reg_ctrl_run && (state_q == ENUM_STATE_TRANSMIT);

  neopixel_stream_counters #(
    .BUFFER_END (BUFFER_END)
  ) u_counters (
    .clk7mhz           (clk7mhz),
    .reset             (reset),
    .init              (reg_ctrl_init),
    .advance           (stream_output),
    .mode_32bit        (reg_ctrl_32bit),
    .limit             (reg_ctrl_limit),
    .reg_max           (reg_max),
    .bit_pattern_index (bit_pattern_index),
    .bit_in_byte       (bit_in_byte),
    .mem_addr          (memAddr),
    .pixel_of          (pixel_of)
  );

  always_comb begin
    data_bit   = memData[3'd7 - bit_in_byte];
    high_ticks = data_bit ? HIGH_TICKS_ONE : HIGH_TICKS_ZERO;
  end

  always_comb begin
    state_d       = state_q;
    delay_count_d = delay_count_q;
    pixels_sync_d = pixels_sync_q;
    state_reset_d = state_reset_q;
    run_clear_d   = 1'b0;
    neo_data_d    = 1'b0;
    if (reg_ctrl_init) begin
      state_d       = ENUM_STATE_TRANSMIT;
      delay_count_d = '0;
      pixels_sync_d = 1'b0;
      state_reset_d = 1'b0;
    end else begin
      case (state_q)
        ENUM_STATE_TRANSMIT: begin
          neo_data_d = stream_output && (bit_pattern_index < high_ticks);
          // Raise the sync flags on the entry edge so they span the whole latch reset.
          if (pixel_of) begin
            state_d       = ENUM_STATE_RESET;
            pixels_sync_d = 1'b1;
            state_reset_d = 1'b1;
          end
        end
        ENUM_STATE_RESET: begin
          if (delay_count_q > DELAY_LAST) begin
            delay_count_d = '0;
            pixels_sync_d = 1'b0;
            state_reset_d = 1'b0;
            state_d       = ENUM_STATE_TRANSMIT;
          end else begin
            delay_count_d = delay_count_q + 10'd1;
            pixels_sync_d = 1'b1;
            state_reset_d = 1'b1;
            run_clear_d   = (delay_count_q == DELAY_LAST) && !reg_ctrl_loop;
          end
        end
        default: begin
          state_d = ENUM_STATE_TRANSMIT;
        end
      endcase
    end
  end

  always_ff @(posedge clk7mhz) begin
    if (reset) begin
      state_q       <= ENUM_STATE_TRANSMIT;
      delay_count_q <= '0;
      neo_data_q    <= 1'b0;
      pixels_sync_q <= 1'b0;
      state_reset_q <= 1'b0;
      run_clear_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      delay_count_q <= delay_count_d;
      neo_data_q    <= neo_data_d;
      pixels_sync_q <= pixels_sync_d;
      state_reset_q <= state_reset_d;
      run_clear_q   <= run_clear_d;
    end
  end

  assign neoData    = neo_data_q;
  assign neoState   = state_q;
  assign pixelsSync = pixels_sync_q;
  assign stateReset = state_reset_q;
  assign runClear   = run_clear_q;

endmodule

// File: tb/tb_neopixel_stream_engine.sv
// Directed bench for neopixel_stream_engine with an 8-byte buffer and a short latch reset.
module tb_neopixel_stream_engine;

  localparam int BUFFER_END  = 7;
  localparam int RESET_DELAY = 10;

  logic        clk7mhz = 1'b0;
  logic        reset;
  logic        reg_ctrl_init;
  logic        reg_ctrl_run;
  logic        reg_ctrl_loop;
  logic        reg_ctrl_limit;
  logic        reg_ctrl_32bit;
  logic [12:0] reg_max;
  logic [2:0]  memAddr;
  logic [7:0]  memData;
  logic        neoData;
  logic        neoState;
  logic        pixelsSync;
  logic        stateReset;
  logic        runClear;

  logic [7:0]  mem [0:7];

  int checks = 0;
  int errors = 0;

  int rc_total   = 0;
  int st_total   = 0;
  int sync_total = 0;
  int nd_total   = 0;

  int hi_width [8];
  int exp_width [8];
  int exp_addr32 [5];
  int first_low;
  int bad_addr;
  int seen3;
  int rc_outside;
  int rc0, st0, sync0, nd0;
  int reset_len;

  neopixel_stream_engine #(
    .BUFFER_END  (BUFFER_END),
    .RESET_DELAY (RESET_DELAY)
  ) dut (
    .clk7mhz        (clk7mhz),
    .reset          (reset),
    .reg_ctrl_init  (reg_ctrl_init),
    .reg_ctrl_run   (reg_ctrl_run),
    .reg_ctrl_loop  (reg_ctrl_loop),
    .reg_ctrl_limit (reg_ctrl_limit),
    .reg_ctrl_32bit (reg_ctrl_32bit),
    .reg_max        (reg_max),
    .memAddr        (memAddr),
    .memData        (memData),
    .neoData        (neoData),
    .neoState       (neoState),
    .pixelsSync     (pixelsSync),
    .stateReset     (stateReset),
    .runClear       (runClear)
  );

  always #5 clk7mhz = ~clk7mhz;

  assign memData = mem[memAddr];

  always @(negedge clk7mhz) begin
    if (runClear === 1'b1)   rc_total   = rc_total + 1;
    if (neoState === 1'b1)   st_total   = st_total + 1;
    if (pixelsSync === 1'b1) sync_total = sync_total + 1;
    if (neoData === 1'b1)    nd_total   = nd_total + 1;
  end

  task automatic check(input string tag, input int observed, input int expected);
    checks = checks + 1;
    if (observed !== expected) begin
      errors = errors + 1;
      $display("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk7mhz);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mem[0] = 8'hA5; mem[1] = 8'hFF; mem[2] = 8'h00; mem[3] = 8'h3C;
    mem[4] = 8'h81; mem[5] = 8'h5A; mem[6] = 8'hC3; mem[7] = 8'h0F;
    exp_width  = '{5, 2, 5, 2, 2, 5, 2, 5};
    exp_addr32 = '{1, 2, 4, 5, 6};

    reset = 1'b1; reg_ctrl_init = 1'b0; reg_ctrl_run = 1'b0; reg_ctrl_loop = 1'b0;
    reg_ctrl_limit = 1'b0; reg_ctrl_32bit = 1'b0; reg_max = 13'd0;
    ticks(3);
    check("rst_neoData", neoData, 0);
    check("rst_neoState", neoState, 0);
    check("rst_pixelsSync", pixelsSync, 0);
    check("rst_stateReset", stateReset, 0);
    check("rst_runClear", runClear, 0);
    check("rst_memAddr", memAddr, 0);
    reset = 1'b0;
    tick();

    // 0xA5 bit cells, then the rest of a single non-looping frame
    reg_ctrl_run = 1'b1;
    check("a5_addr_start", memAddr, 0);
    first_low = 0; bad_addr = 0;
    for (int k = 0; k < 8; k++) hi_width[k] = 0;
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (neoData === 1'b1) hi_width[(i - 1) / 8] = hi_width[(i - 1) / 8] + 1;
      if (((i - 1) % 8 == 0) && (neoData !== 1'b1)) first_low = first_low + 1;
      if ((i < 64) && (memAddr !== 3'd0)) bad_addr = bad_addr + 1;
    end
    for (int k = 0; k < 8; k++) check($sformatf("a5_width%0d", k), hi_width[k], exp_width[k]);
    check("a5_cell_starts_high", first_low, 0);
    check("a5_addr_hold0", bad_addr, 0);
    check("a5_addr_next", memAddr, 1);

    ticks(447);
    check("frame_state_before_end", neoState, 0);
    rc0 = rc_total; st0 = st_total; sync0 = sync_total; nd0 = nd_total;
    tick();
    check("frame_state_reset", neoState, 1);
    check("frame_sync_reset", pixelsSync, 1);
    check("frame_statereset", stateReset, 1);
    rc_outside = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (runClear === 1'b1) begin
        if (neoState !== 1'b1) rc_outside = rc_outside + 1;
        reg_ctrl_run = 1'b0;
      end
    end
    check("frame_reset_len", st_total - st0, 12);
    check("frame_sync_len", sync_total - sync0, 12);
    check("frame_runclear_pulses", rc_total - rc0, 1);
    check("frame_runclear_in_reset", rc_outside, 0);
    check("frame_data_quiet", nd_total - nd0, 0);
    check("frame_back_transmit", neoState, 0);
    check("frame_addr_idle", memAddr, 0);

    // looping frame: no run clear, restart after latch reset
    reg_ctrl_loop = 1'b1;
    reg_ctrl_run  = 1'b1;
    rc0 = rc_total;
    ticks(512);
    check("loop_state_reset", neoState, 1);
    ticks(12);
    check("loop_state_transmit", neoState, 0);
    check("loop_addr_restart", memAddr, 0);
    tick();
    check("loop_data_restart", neoData, 1);
    check("loop_no_runclear", rc_total - rc0, 0);
    reg_ctrl_run = 1'b0;
    ticks(2);

    // 32-bit stride, unlimited: last pixel at address 4, byte 3 never read
    reg_ctrl_32bit = 1'b1;
    reg_ctrl_run   = 1'b1;
    check("w32_addr_start", memAddr, 0);
    seen3 = 0;
    for (int i = 1; i <= 384; i++) begin
      tick();
      if (memAddr === 3'd3) seen3 = seen3 + 1;
      if ((i % 64 == 0) && (i < 384)) check($sformatf("w32_addr_%0d", i), memAddr, exp_addr32[i / 64 - 1]);
      if (i == 383) check("w32_state_before_end", neoState, 0);
    end
    check("w32_state_reset", neoState, 1);
    check("w32_byte3_unused", seen3, 0);
    reg_ctrl_run = 1'b0;
    ticks(14);
    check("w32_back_transmit", neoState, 0);

    // limited to pixel 2 in 8-bit mode
    reg_ctrl_32bit = 1'b0;
    reg_ctrl_limit = 1'b1;
    reg_max        = 13'd2;
    reg_ctrl_run   = 1'b1;
    for (int i = 1; i <= 192; i++) begin
      tick();
      if (i == 64)  check("lim_addr1", memAddr, 1);
      if (i == 128) check("lim_addr2", memAddr, 2);
      if (i == 191) check("lim_state_before_end", neoState, 0);
    end
    check("lim_state_reset", neoState, 1);
    reg_ctrl_run = 1'b0;
    ticks(14);

    // init pulsed mid-bit
    reg_ctrl_limit = 1'b0;
    reg_ctrl_run   = 1'b1;
    ticks(67);
    check("init_bit_pre_addr", memAddr, 1);
    check("init_bit_pre_data", neoData, 1);
    reg_ctrl_init = 1'b1;
    tick();
    check("init_bit_addr", memAddr, 0);
    check("init_bit_data", neoData, 0);
    check("init_bit_state", neoState, 0);
    reg_ctrl_init = 1'b0;
    tick();
    check("init_bit_restart", neoData, 1);
    check("init_bit_restart_addr", memAddr, 0);

    // init pulsed mid latch reset; the following reset must be full length
    reg_ctrl_run = 1'b0;
    tick();
    reg_ctrl_limit = 1'b1;
    reg_max        = 13'd0;
    reg_ctrl_run   = 1'b1;
    ticks(64);
    check("init_rst_entered", neoState, 1);
    ticks(5);
    reg_ctrl_init = 1'b1;
    tick();
    check("init_rst_state", neoState, 0);
    check("init_rst_sync", pixelsSync, 0);
    check("init_rst_statereset", stateReset, 0);
    check("init_rst_data", neoData, 0);
    reg_ctrl_init = 1'b0;
    ticks(64);
    check("init_rst_again", neoState, 1);
    reset_len = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (neoState !== 1'b1) break;
      reset_len = reset_len + 1;
    end
    check("init_rst_full_len", reset_len, 12);

    // run dropped mid-frame restarts from address 0
    reg_ctrl_run   = 1'b0;
    reg_ctrl_limit = 1'b0;
    ticks(2);
    reg_ctrl_run = 1'b1;
    ticks(100);
    check("drop_pre_addr", memAddr, 1);
    reg_ctrl_run = 1'b0;
    tick();
    check("drop_addr", memAddr, 0);
    check("drop_data", neoData, 0);
    reg_ctrl_run = 1'b1;
    tick();
    check("drop_restart_addr", memAddr, 0);
    check("drop_restart_data", neoData, 1);

    // reset pulsed mid-bit and mid latch reset
    ticks(70);
    reset = 1'b1;
    tick();
    check("rstp_bit_addr", memAddr, 0);
    check("rstp_bit_data", neoData, 0);
    reset = 1'b0;
    reg_ctrl_limit = 1'b1;
    reg_max        = 13'd0;
    ticks(64);
    check("rstp_entered", neoState, 1);
    ticks(3);
    reset = 1'b1;
    tick();
    check("rstp_state", neoState, 0);
    check("rstp_sync", pixelsSync, 0);
    reset = 1'b0;
    reg_ctrl_run = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/neopixel_stream_engine.md
Name: neopixel_stream_engine

Overview:
Serialises pixel bytes from an external byte-wide pixel buffer into a WS2812 ("NeoPixel") single-wire waveform at 7 MHz (8 ticks per LED bit). It owns the bit/pattern/pixel counters, the transmit/latch-reset state machine and the output encoder. It sits between the bus-side register/buffer block and the LED pin.

Parameters:
BUFFER_END, 31, last valid byte address of the pixel buffer (buffer size BUFFER_END+1).
RESET_DELAY, 385, latch-reset length control in clk7mhz ticks (55 us).
BUFFER_BITS (localparam), clog2(BUFFER_END+1), width of byte addresses.

Ports:
clk7mhz  in  1  clock; one clock; reset is synchronous and active-high
reset  in  1  synchronous active-high reset
reg_ctrl_init  in  1  soft reset of the stream; same effect as reset
reg_ctrl_run  in  1  enable transmission
reg_ctrl_loop  in  1  1 = repeat frames; 0 = request run clear after one frame
reg_ctrl_limit  in  1  1 = last pixel taken from reg_max; 0 = from BUFFER_END
reg_ctrl_32bit  in  1  1 = 4-byte pixel stride, 24 bits sent per pixel; 0 = 8 bits per byte
reg_max  in  13  last pixel number when limited
memAddr  out  BUFFER_BITS  byte address into pixel buffer
memData  in  8  byte at memAddr; asynchronous, same-cycle read
neoData  out  1  LED waveform, registered
neoState  out  1  0 = TRANSMIT, 1 = RESET
pixelsSync  out  1  high while in latch reset
stateReset  out  1  status copy of the latch-reset phase
runClear  out  1  one-cycle pulse; the owner of reg_ctrl_run must clear it

Behaviour:
- On reset or reg_ctrl_init, everything goes to 0: counters, state=TRANSMIT, delay counter; neoData, pixelsSync, stateReset and runClear go to 0 at the next edge.
- Counters:
  - bit_pattern_index: 3 bits.
  - pixel_bit_index: 5 bits.
  - pixel_index: BUFFER_BITS bits.
  - delay_count: 10 bits.
- stream_output = reg_ctrl_run and state==TRANSMIT.
- stream_reset = state==RESET. This is independent of run, so a started latch reset always completes.
- TRANSMIT with run=0: all counters are held at 0 and neoData=0. A deasserted run aborts the frame; the next run starts at pixel 0.
- Counter advance when stream_output is high:
  - bit_pattern_index increments every tick and wraps 7->0.
  - pattern_of = (bit_pattern_index==7).
  - last_bit = 23 in 32-bit mode, else 7.
  - bit_of = pattern_of and pixel_bit_index==last_bit.
  - On pattern_of, pixel_bit_index increments; it wraps to 0 on bit_of.
- Pixel end and wrap:
  - pixel_index_max:
    - limit=1: reg_max (8-bit mode) or reg_max<<2 (32-bit mode), truncated to BUFFER_BITS.
    - limit=0: BUFFER_END (8-bit mode) or BUFFER_END & ~3 (32-bit mode).
  - pixel_of = bit_of and pixel_index >= pixel_index_max.
  - On bit_of without pixel_of: pixel_index += 4 (32-bit mode) or += 1 (8-bit mode).
  - On pixel_of: pixel_index <= 0 and state <= RESET.
- Addressing:
  - memAddr = pixel_index + (32-bit mode ? pixel_bit_index[4:3] : 0).
  - Bit sent = memData[7 - pixel_bit_index[2:0]], MSB first; byte order in memory is kept as-is.
- Encoding: neoData is registered one tick after the counters.
  - Bit 1: high during ticks 0..4, low during ticks 5..7.
  - Bit 0: high during ticks 0..1, low during ticks 2..7.
  - neoData = 0 whenever stream_output is 0.
- RESET state:
  - Each tick: delay_count++, pixelsSync<=1, stateReset<=1, neoData=0.
  - When delay_count==RESET_DELAY and loop=0: runClear pulses for 1 cycle.
  - When delay_count > RESET_DELAY: delay_count<=0, pixelsSync<=0, stateReset<=0, state<=TRANSMIT.
  - RESET therefore lasts RESET_DELAY+2 ticks.
- reg_ctrl_32bit and reg_ctrl_limit are sampled live. Changing them mid-frame is unsupported; the pixel_index >= max compare guarantees termination anyway.
- reset and init take priority over all counter and state updates in the same cycle.

Decomposition:
- Shared package: ENUM_STATE_TRANSMIT=0, ENUM_STATE_RESET=1, BUFFER_END_DEFAULT, RESET_DELAY_DEFAULT, a CLOG2 helper, and the high-tick constants 5 (bit 1) and 2 (bit 0).
- One natural sub-module, neopixel_stream_counters: the three counters, the overflow flags and pixel_index_max. The top holds the state machine, the delay counter and the encoder.

Test Plan:
- Bench overrides BUFFER_END=7, RESET_DELAY=10.
- 8-bit, byte 0 = 0xA5, run=1 -> neoData high widths 5,2,5,2,2,5,2,5 ticks, each bit period 8 ticks; memAddr=0 for 64 ticks, then 1.
- Full frame, loop=0 -> after 512 ticks neoState=1 and pixelsSync=1 for 12 ticks; runClear pulses once on the 11th RESET tick; neoData stays 0 with run dropped afterwards.
- loop=1 -> no runClear; after 12 reset ticks memAddr returns to 0 and transmission restarts.
- 32-bit, limit=0 -> memAddr 0,1,2 (64 ticks each), then 4,5,6, then RESET; byte 3 is never addressed.
- limit=1, reg_max=2, 8-bit -> memAddr 0,1,2, then RESET after 192 ticks.
- reg_ctrl_init or reset pulsed mid-bit and mid-RESET -> counters 0, state TRANSMIT, pixelsSync=0, neoData=0 at the following edge; drop run mid-frame -> restart from memAddr 0.
